// File: rtl/dec_lut_decoder20_clk.sv
// Iterative code-word to index decoder: N = floor(W / DIV), one quotient bit per clock.
// Optional DEC_CLAMP_EN clamps N to 2^(N_BITS-1)-1 before it is written.
module dec_lut_decoder20_clk #(
   parameter int W_BITS = 34,
   parameter int N_BITS = 21,
   parameter int DIV    = 16383
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [W_BITS-1:0] W,
   output logic [N_BITS-1:0] N,
   output logic              found
);

   localparam int REM_W = $clog2(DIV) + 1;
   localparam int CNT_W = $clog2(N_BITS + 1);
   localparam logic [REM_W:0] DIV_X = (REM_W + 1)'(DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t            state, state_d;
   logic [W_BITS-1:0] wq, wq_d;
   logic [REM_W-1:0]  rem, rem_d;
   logic [N_BITS-1:0] quo, quo_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [N_BITS-1:0] n_q, n_d;
   logic              done, done_d;
   logic              pend, pend_d;

   logic [REM_W:0]    rem_sh;
   logic              q_bit;
   logic [N_BITS-1:0] result;
   logic              w_same;

   assign w_same = (W == wq);
   assign found  = done & w_same;
   assign N      = n_q;

   // quo holds the not-yet-consumed dividend bits; quotient bits shift in at the LSB
   assign rem_sh = {rem, quo[N_BITS-1]};
   assign q_bit  = (rem_sh >= DIV_X);

`ifdef DEC_CLAMP_EN
   always_comb begin
      result = {quo[N_BITS-2:0], q_bit};
      if (result[N_BITS-1])
         result = {1'b0, {(N_BITS-1){1'b1}}};
   end
`else
   assign result = {quo[N_BITS-2:0], q_bit};
`endif

   always_comb begin
      state_d = state;
      wq_d    = wq;
      rem_d   = rem;
      quo_d   = quo;
      cnt_d   = cnt;
      n_d     = n_q;
      done_d  = done;
      pend_d  = pend;
      unique case (state)
         IDLE: begin
            if (pend || !w_same) begin
               // high bits seed the remainder; they are below DIV so their quotient bits are 0
               wq_d    = W;
               rem_d   = REM_W'(W[W_BITS-1:N_BITS]);
               quo_d   = W[N_BITS-1:0];
               cnt_d   = '0;
               done_d  = 1'b0;
               pend_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            rem_d = q_bit ? REM_W'(rem_sh - DIV_X) : REM_W'(rem_sh);
            quo_d = {quo[N_BITS-2:0], q_bit};
            cnt_d = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               state_d = IDLE;
               if (w_same) begin
                  n_d    = result;
                  done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         wq    <= '0;
         rem   <= '0;
         quo   <= '0;
         cnt   <= '0;
         n_q   <= '0;
         done  <= 1'b0;
         pend  <= 1'b1;
      end else begin
         state <= state_d;
         wq    <= wq_d;
         rem   <= rem_d;
         quo   <= quo_d;
         cnt   <= cnt_d;
         n_q   <= n_d;
         done  <= done_d;
         pend  <= pend_d;
      end
   end

endmodule

// File: tb/tb_dec_lut_decoder20_clk.sv
// Directed bench for dec_lut_decoder20_clk.
// Expected indices are hand-computed floor(W / 16383).
module tb_dec_lut_decoder20_clk;

   logic        clk;
   logic        rst_n;
   logic [33:0] W;
   logic [20:0] N;
   logic        found;

   int checks;
   int failures;
   int first;

`ifdef DEC_CLAMP_EN
   localparam logic [20:0] MAX_EXP = 21'd1048575;
`else
   localparam logic [20:0] MAX_EXP = 21'd1048640;
`endif

   dec_lut_decoder20_clk dut (
      .clk   (clk),
      .rst_n (rst_n),
      .W     (W),
      .N     (N),
      .found (found)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic decode(input string tag, input logic [33:0] w,
                         input logic [20:0] prev, input logic [20:0] e);
      W = w;
      #1;
      chk({tag, "_drop"}, 64'(found), 64'd0);
      chk({tag, "_hold"}, 64'(N), 64'(prev));
      edges(21);
      chk({tag, "_early"}, 64'(found), 64'd0);
      edges(1);
      chk({tag, "_found"}, 64'(found), 64'd1);
      chk({tag, "_n"}, 64'(N), 64'(e));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      W        = '0;
      #2;
      chk("rst_found", 64'(found), 64'd0);
      chk("rst_n", 64'(N), 64'd0);
      edges(2);
      chk("rst_found2", 64'(found), 64'd0);
      rst_n = 1'b1;
      edges(21);
      chk("zero_early", 64'(found), 64'd0);
      edges(1);
      chk("zero_found", 64'(found), 64'd1);
      chk("zero_n", 64'(N), 64'd0);

      decode("big", 34'd17178804225, 21'd0, 21'd1048575);
      decode("big_m1", 34'd17178820607, 21'd1048575, 21'd1048575);
      decode("one", 34'd16383, 21'd1048575, 21'd1);
      decode("below", 34'd16382, 21'd1, 21'd0);
      decode("two", 34'd32766, 21'd0, 21'd2);
      decode("max", 34'h3_FFFF_FFFF, 21'd2, MAX_EXP);

      W = 34'd100000;
      #1;
      chk("mid_drop", 64'(found), 64'd0);
      edges(5);
      W = 34'd8191500;
      first = -1;
      for (int j = 1; j <= 45; j++) begin
         edges(1);
         if (found && first < 0) first = j;
      end
      chk("mid_latency", 64'(first), 64'd39);
      chk("mid_found", 64'(found), 64'd1);
      chk("mid_n", 64'(N), 64'd500);

      W = 34'd114681;
      edges(10);
      rst_n = 1'b0;
      #1;
      chk("arst_n", 64'(N), 64'd0);
      chk("arst_found", 64'(found), 64'd0);
      edges(2);
      rst_n = 1'b1;
      edges(21);
      chk("arst_early", 64'(found), 64'd0);
      edges(1);
      chk("arst_found2", 64'(found), 64'd1);
      chk("arst_n2", 64'(N), 64'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
